// File: rtl/lzw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lzw_pkg
// Description : Shared constants and types for the LZW dictionary RAM
//               controller: dictionary geometry, empty-entry marker and the
//               controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package lzw_pkg;

    localparam int DICT_ADDR_W = 12;
    localparam int DICT_DATA_W = 13;
    localparam int DICT_DEPTH  = 4096;

    // Marker written into every entry by a dictionary clear.
    localparam logic [DICT_DATA_W-1:0] DICT_EMPTY = 13'h1FFF;

    typedef enum logic [0:0] {
        READY = 1'b0,
        CLEAR = 1'b1
    } ctrl_state_e;

endpackage : lzw_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin arbiter with combinational grants
//               and a registered priority pointer. With a single requester
//               pending it is granted at once; with both pending the side
//               that was not granted most recently wins.
// Ports       : clk, rst_n       - clock, asynchronous active-low reset
//               en_i             - grants allowed this cycle
//               req0_i / req1_i  - requests (req0 = read side)
//               gnt0_o / gnt1_o  - one-hot (or zero) grants
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    // prio1_q = 1 means requester 1 wins a tie; reset favours requester 0.
    logic prio1_q;
    logic prio1_d;

    always_comb begin
        gnt0_o  = 1'b0;
        gnt1_o  = 1'b0;
        prio1_d = prio1_q;
        if (en_i) begin
            if (req0_i && (!req1_i || !prio1_q)) begin
                gnt0_o = 1'b1;
            end else if (req1_i) begin
                gnt1_o = 1'b1;
            end
        end
        if (gnt0_o) prio1_d = 1'b1;
        if (gnt1_o) prio1_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prio1_q <= 1'b0;
        else        prio1_q <= prio1_d;
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/dict_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dict_ram_ctrl
// Description : Sequencer/arbiter for one LZW dictionary RAM. Shares the RAM
//               port between a read requester and a write requester using
//               round-robin, and performs a full dictionary clear (every
//               entry set to CLR_VAL) on request.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               clr_req / clr_busy         - clear start pulse / clear active
//               rd_req, rd_addr, rd_gnt    - read request handshake
//               rd_valid, rd_data_o        - read response (grant + 2 cycles)
//               wr_req, wr_addr, wr_data,
//               wr_gnt                     - write request handshake
//               ram_en, ram_wren, ram_addr,
//               ram_wr_data, ram_rd_data   - registered RAM port
// Options     : DICT_AUTO_CLEAR_EN - when defined, the controller leaves
//               reset in CLEAR and wipes the dictionary before any grant.
// Revision    : 1.0 - initial release
// ============================================================================
module dict_ram_ctrl
    import lzw_pkg::*;
#(
    parameter int                ADDR_W  = DICT_ADDR_W,
    parameter int                DATA_W  = DICT_DATA_W,
    parameter logic [DATA_W-1:0] CLR_VAL = DICT_EMPTY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              clr_busy,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic              ram_en,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] ram_rd_data
);

`ifdef DICT_AUTO_CLEAR_EN
    localparam ctrl_state_e RST_STATE = CLEAR;
`else
    localparam ctrl_state_e RST_STATE = READY;
`endif

    ctrl_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              clr_busy_q;
    logic              ram_en_q, ram_en_d;
    logic              ram_wren_q, ram_wren_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wr_data_q, ram_wr_data_d;
    logic              rd_pend_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              grant_en;

    // A clear request blocks grants in the very cycle it arrives, so nothing
    // is accepted that would land on the RAM after the clear has begun.
    assign grant_en = (state_q == READY) && !clr_req;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (grant_en),
        .req0_i (rd_req),
        .req1_i (wr_req),
        .gnt0_o (rd_gnt),
        .gnt1_o (wr_gnt)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ram_en_d      = 1'b0;
        ram_wren_d    = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_wr_data_d = ram_wr_data_q;
        case (state_q)
            READY: begin
                if (clr_req) begin
                    state_d = CLEAR;
                end else if (rd_gnt) begin
                    ram_en_d   = 1'b1;
                    ram_addr_d = rd_addr;
                end else if (wr_gnt) begin
                    ram_en_d      = 1'b1;
                    ram_wren_d    = 1'b1;
                    ram_addr_d    = wr_addr;
                    ram_wr_data_d = wr_data;
                end
            end
            CLEAR: begin
                ram_en_d      = 1'b1;
                ram_wren_d    = 1'b1;
                ram_addr_d    = cnt_q;
                ram_wr_data_d = CLR_VAL;
                if (cnt_q == '1) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = READY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RST_STATE;
            cnt_q         <= '0;
            clr_busy_q    <= 1'b0;
            ram_en_q      <= 1'b0;
            ram_wren_q    <= 1'b0;
            ram_addr_q    <= '0;
            ram_wr_data_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            clr_busy_q    <= (state_d == CLEAR);
            ram_en_q      <= ram_en_d;
            ram_wren_q    <= ram_wren_d;
            ram_addr_q    <= ram_addr_d;
            ram_wr_data_q <= ram_wr_data_d;
        end
    end

    // Read return path. The RAM presents data while the read strobe is on
    // its pins (its address register is ram_addr_q), so the word is captured
    // at the end of that cycle: grant N, RAM access N+1, rd_valid N+2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_pend_q  <= rd_gnt;
            rd_valid_q <= rd_pend_q;
            if (rd_pend_q) rd_data_q <= ram_rd_data;
        end
    end

    assign clr_busy    = clr_busy_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data_o   = rd_data_q;
    assign ram_en      = ram_en_q;
    assign ram_wren    = ram_wren_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wr_data = ram_wr_data_q;

endmodule : dict_ram_ctrl
`default_nettype wire
